// File: rtl/btn_press_classifier_pkg.sv
// Shared state encodings and default timing for the button gesture classifier.
// The buzzer control FSM imports the same definitions.
package btn_press_classifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HOLD   = 3'd4
  } btn_state_e;

  // Defaults assume a 100 MHz clock.
  localparam int unsigned DEF_LONG_LIMIT    = 100_000_000;
  localparam int unsigned DEF_DOUBLE_GAP    = 30_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 20_000_000;
  localparam int unsigned DEF_CNT_W         = 27;

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a clock-synchronous button level and flags its rising and falling edges.
// The register clears on reset, so a level held high through reset reads as a fresh rise.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced button gestures into short, double and long presses with auto-repeat.
// Outputs are registered one-cycle event pulses; busy mirrors "FSM not idle" one cycle after the decision.
module btn_press_classifier
  import btn_press_classifier_pkg::*;
#(
  parameter int unsigned LONG_LIMIT    = DEF_LONG_LIMIT,
  parameter int unsigned DOUBLE_GAP    = DEF_DOUBLE_GAP,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clean_btn,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  // A limit counts as reached on the last cycle of the interval, i.e. cnt == LIMIT-1.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic rise;
  logic fall;

  btn_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (clean_btn),
    .rise  (rise),
    .fall  (fall)
  );

  btn_state_e       state;
  btn_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic             cnt_restart;
  logic             short_nx;
  logic             double_nx;
  logic             long_nx;
  logic             repeat_nx;

  always_comb begin
    state_nx    = state;
    cnt_restart = 1'b0;
    short_nx    = 1'b0;
    double_nx   = 1'b0;
    long_nx     = 1'b0;
    repeat_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) state_nx = ST_PRESS1;
      end
      ST_PRESS1: begin
        // A release on the very cycle the limit is reached still counts as a short press.
        if (fall) begin
          state_nx = ST_GAP;
        end else if (cnt == LONG_LAST) begin
          long_nx  = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          state_nx = ST_IDLE;
        end else if (cnt == REPEAT_LAST) begin
          repeat_nx   = 1'b1;
          cnt_restart = 1'b1;
        end
      end
      ST_GAP: begin
        // A re-press on the last gap cycle still makes a double press.
        if (rise) begin
          state_nx = ST_PRESS2;
        end else if (cnt == GAP_LAST) begin
          short_nx = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          double_nx = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state || cnt_restart) cnt <= '0;
      else if (cnt != CNT_MAX)              cnt <= cnt + 1'b1;
      short_press  <= short_nx;
      double_press <= double_nx;
      long_press   <= long_nx;
      repeat_pulse <= repeat_nx;
      busy         <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Randomized gesture bench: a gesture-level reference model predicts every pulse and
// its cycle; a negedge monitor matches DUT pulses against the expected queue.
module tb_btn_press_classifier;

  localparam int LONG = 20;
  localparam int DG   = 10;
  localparam int REP  = 5;
  localparam int CW   = 5;

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_DOUBLE = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clean_btn = 1'b0;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  btn_press_classifier #(
    .LONG_LIMIT    (LONG),
    .DOUBLE_GAP    (DG),
    .REPEAT_PERIOD (REP),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clean_btn    (clean_btn),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [31:0] ev(input logic [1:0] kind, input int c);
    logic [31:0] cv;
    cv = c;
    return {kind, cv[29:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic record_fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected no such event (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- reference model ----------------
  // A gesture is: press a cycles, release g cycles, press b cycles (b=0: none), then idle.
  // t0 is the first cycle the button reads high. Times follow the gesture rules directly:
  // long fires LONG cycles into the hold, repeats every REP after, a short needs DG quiet
  // gap cycles, and a re-press within the gap pairs into a double press.
  task automatic model(input int t0, input int a, input int g, input int b);
    int t;
    int p;
    int nx;
    t  = t0;
    p  = a;
    nx = b;
    while (p > 0) begin
      if (p >= LONG + 1) begin
        exp_q.push_back(ev(EV_LONG, t + LONG + 1));
        for (int k = 1; LONG + k * REP <= p - 1; k++)
          exp_q.push_back(ev(EV_REPEAT, t + LONG + k * REP + 1));
        t  = t + p + g;
        p  = nx;
        nx = 0;
      end else if (nx > 0 && g <= DG) begin
        exp_q.push_back(ev(EV_DOUBLE, t + p + g + nx + 1));
        p = 0;
      end else begin
        exp_q.push_back(ev(EV_SHORT, t + p + DG + 1));
        t  = t + p + g;
        p  = nx;
        nx = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      clean_btn = v;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gesture(input int p1, input int g, input int p2, input bit rel_reset);
    clean_btn = 1'b1;
    if (rel_reset) reset = 1'b0;
    model(cyc, p1, g, p2);
    check("busy_before_press", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("busy_after_rise", 32'(busy), 32'd1);
    hold(1'b1, p1 - 1);
    if (p2 > 0) begin
      hold(1'b0, g);
      hold(1'b1, p2);
    end
    hold(1'b0, DG + 6);
    check("busy_back_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [3:0]  pv;
    logic [1:0]  kind;
    logic [31:0] act;
    logic [31:0] cv;
    pv = {short_press, double_press, long_press, repeat_pulse};
    cv = cyc;
    if (pv != 4'd0) begin
      check("pulse_exclusive", 32'($countones(pv)), 32'd1);
      if (short_press)       kind = EV_SHORT;
      else if (double_press) kind = EV_DOUBLE;
      else if (long_press)   kind = EV_LONG;
      else                   kind = EV_REPEAT;
      act = ev(kind, cyc);
      if (exp_q.size() == 0) record_fail("unexpected_pulse", act);
      else check("pulse_match", act, exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0][29:0] < cv[29:0]) begin
      check("missed_pulse", 32'hFFFF_FFFF, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    reset     = 1'b1;
    clean_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({short_press, double_press, long_press, repeat_pulse, busy}), 32'd0);
    reset = 1'b0;
    hold(1'b0, 3);

    // directed gestures, including gap and long-limit boundaries
    gesture(5, 0, 0, 0);
    gesture(5, 4, 3, 0);
    gesture(32, 0, 0, 0);
    gesture(5, DG - 1, 3, 0);
    gesture(5, DG, 3, 0);
    gesture(5, DG + 1, 3, 0);
    gesture(LONG, 0, 0, 0);
    gesture(LONG + 1, 0, 0, 0);
    gesture(LONG + REP, 0, 0, 0);
    gesture(LONG + REP + 1, 0, 0, 0);
    gesture(1, 1, 1, 0);
    gesture(3, 2, 40, 0);

    // randomized gestures
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: gesture($urandom_range(1, LONG), 0, 0, 0);
        1: gesture($urandom_range(1, LONG), $urandom_range(1, DG + 2), $urandom_range(1, 30), 0);
        2: gesture($urandom_range(LONG + 1, LONG + 4 * REP), 0, 0, 0);
        default: gesture($urandom_range(LONG + 1, LONG + 2 * REP), $urandom_range(1, 4),
                         $urandom_range(1, LONG), 0);
      endcase
    end

    // asynchronous reset in the middle of PRESS1 drops the gesture
    hold(1'b1, 11);
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_pulses", 32'({short_press, double_press, long_press, repeat_pulse}), 32'd0);
    hold(1'b0, 3);
    reset = 1'b0;
    hold(1'b0, 50);
    check("quiet_after_reset_busy", 32'(busy), 32'd0);

    // button held through reset release is a fresh press
    reset = 1'b1;
    hold(1'b1, 3);
    gesture(LONG + 2, 0, 0, 1);

    hold(1'b0, 5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
